// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush scheduler.
package pipe_hazard_ctrl_pkg;

    // Pipeline datapath word width and exception cause-code width.
    localparam int F_W   = 32;
    localparam int EXC_W = 5;

    // Default HI/LO busy durations after a multiply or divide issues in E.
    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    // Scheduler states: normal operation, or the one-cycle flush after an exception.
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } fsm_t;

endpackage

// File: rtl/md_busy_cnt.sv
// Load/decrement counter tracking how long HI/LO stays busy.
module md_busy_cnt
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy
);

    logic [CNT_W-1:0] cnt;

    // A new multiply/divide reloads the count; otherwise it drains toward zero and stops there.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush scheduler producing PC and pipeline-register controls.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_D,
    input  logic [4:0] rt_D,
    input  logic       use_rs_D,
    input  logic       use_rt_D,
    input  logic       md_use_D,
    input  logic       memread_E,
    input  logic [4:0] rd_E,
    input  logic       md_start_E,
    input  logic       md_div_E,
    input  logic       eret_D,
    input  logic       epc_wr_E,
    input  logic       epc_wr_M,
    input  logic       exc_req_M,
    output logic       pc_en,
    output logic       IF_ID_en,
    output logic       IF_ID_clr,
    output logic       ID_EX_clr,
    output logic       int_clr,
    output logic       ERET_PC_sel,
    output logic       md_busy
);

    fsm_t             fsm;
    logic             cnt_busy;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             lu;
    logic             ms;
    logic             es;
    logic             stall;

    // A multiply/divide squashed by a same-cycle exception must not start the busy window.
    assign cnt_load     = md_start_E & ~exc_req_M;
    assign cnt_load_val = md_div_E ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);

    md_busy_cnt #(
        .CNT_W(CNT_W)
    ) u_md_busy_cnt (
        .clk     (clk),
        .reset   (reset),
        .load    (cnt_load),
        .load_val(cnt_load_val),
        .busy    (cnt_busy)
    );

    // Load-use against a real register, HI/LO access while busy, and ERET waiting on an EPC write.
    assign lu    = memread_E & (rd_E != 5'd0) &
                   ((use_rs_D & (rs_D == rd_E)) | (use_rt_D & (rt_D == rd_E)));
    assign ms    = md_use_D & (cnt_busy | md_start_E);
    assign es    = eret_D & (epc_wr_E | epc_wr_M);
    assign stall = lu | ms | es;

    // An accepted exception forces one flush cycle; every other case returns to normal running.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fsm <= ST_RUN;
        end else if (exc_req_M) begin
            fsm <= ST_FLUSH;
        end else begin
            fsm <= ST_RUN;
        end
    end

    // Control outputs in priority order: reset, exception, flush, stall, ERET, normal.
    always_comb begin
        pc_en       = 1'b1;
        IF_ID_en    = 1'b1;
        IF_ID_clr   = 1'b0;
        ID_EX_clr   = 1'b0;
        int_clr     = 1'b0;
        ERET_PC_sel = 1'b0;
        md_busy     = cnt_busy;
        if (!reset) begin
            pc_en     = 1'b0;
            IF_ID_en  = 1'b0;
            IF_ID_clr = 1'b1;
            ID_EX_clr = 1'b1;
            md_busy   = 1'b0;
        end else if (exc_req_M) begin
            int_clr   = 1'b1;
            IF_ID_en  = 1'b0;
            IF_ID_clr = 1'b1;
            ID_EX_clr = 1'b1;
        end else if (fsm == ST_FLUSH) begin
            IF_ID_en  = 1'b0;
            IF_ID_clr = 1'b1;
            ID_EX_clr = 1'b1;
        end else if (stall) begin
            pc_en     = 1'b0;
            IF_ID_en  = 1'b0;
            ID_EX_clr = 1'b1;
        end else if (eret_D) begin
            ERET_PC_sel = 1'b1;
            IF_ID_clr   = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for the pipeline stall/flush scheduler.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] rs_D;
    logic [4:0] rt_D;
    logic       use_rs_D;
    logic       use_rt_D;
    logic       md_use_D;
    logic       memread_E;
    logic [4:0] rd_E;
    logic       md_start_E;
    logic       md_div_E;
    logic       eret_D;
    logic       epc_wr_E;
    logic       epc_wr_M;
    logic       exc_req_M;
    logic       pc_en;
    logic       IF_ID_en;
    logic       IF_ID_clr;
    logic       ID_EX_clr;
    logic       int_clr;
    logic       ERET_PC_sel;
    logic       md_busy;

    int compared;
    int mismatched;

    // Expected {pc_en, IF_ID_en, IF_ID_clr, ID_EX_clr, int_clr, ERET_PC_sel}.
    localparam logic [5:0] O_RESET = 6'b001100;
    localparam logic [5:0] O_RUN   = 6'b110000;
    localparam logic [5:0] O_STALL = 6'b000100;
    localparam logic [5:0] O_FLUSH = 6'b101100;
    localparam logic [5:0] O_ERET  = 6'b111001;
    // Exception row, IF_ID_clr excluded: {pc_en, IF_ID_en, ID_EX_clr, int_clr, ERET_PC_sel}.
    localparam logic [4:0] O_EXC   = 5'b10110;

    pipe_hazard_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .rs_D       (rs_D),
        .rt_D       (rt_D),
        .use_rs_D   (use_rs_D),
        .use_rt_D   (use_rt_D),
        .md_use_D   (md_use_D),
        .memread_E  (memread_E),
        .rd_E       (rd_E),
        .md_start_E (md_start_E),
        .md_div_E   (md_div_E),
        .eret_D     (eret_D),
        .epc_wr_E   (epc_wr_E),
        .epc_wr_M   (epc_wr_M),
        .exc_req_M  (exc_req_M),
        .pc_en      (pc_en),
        .IF_ID_en   (IF_ID_en),
        .IF_ID_clr  (IF_ID_clr),
        .ID_EX_clr  (ID_EX_clr),
        .int_clr    (int_clr),
        .ERET_PC_sel(ERET_PC_sel),
        .md_busy    (md_busy)
    );

    // Free-running clock, posedges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [6:0] got, input logic [6:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic clearInputs();
        rs_D = 5'd0; rt_D = 5'd0; use_rs_D = 1'b0; use_rt_D = 1'b0;
        md_use_D = 1'b0; memread_E = 1'b0; rd_E = 5'd0;
        md_start_E = 1'b0; md_div_E = 1'b0; eret_D = 1'b0;
        epc_wr_E = 1'b0; epc_wr_M = 1'b0; exc_req_M = 1'b0;
    endtask

    // Samples the full output vector mid-cycle, then advances past the next posedge.
    task automatic applyStimulus(input string tag, input logic [5:0] exp, input logic busy);
        @(negedge clk);
        checkOutput(tag, {pc_en, IF_ID_en, IF_ID_clr, ID_EX_clr, int_clr, ERET_PC_sel, md_busy},
                    {exp, busy});
        @(posedge clk);
        #1;
    endtask

    // Same as applyStimulus but for the exception cycle, where IF_ID_clr is not compared.
    task automatic applyExc(input string tag, input logic busy);
        @(negedge clk);
        checkOutput(tag, {1'b0, pc_en, IF_ID_en, ID_EX_clr, int_clr, ERET_PC_sel, md_busy},
                    {1'b0, O_EXC, busy});
        @(posedge clk);
        #1;
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        clearInputs();
        reset = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus("reset0", O_RESET, 1'b0);
        memread_E = 1'b1; rd_E = 5'd8; rs_D = 5'd8; use_rs_D = 1'b1; exc_req_M = 1'b1;
        applyStimulus("reset_over_inputs", O_RESET, 1'b0);
        clearInputs();
        reset = 1'b1;
        applyStimulus("idle", O_RUN, 1'b0);

        memread_E = 1'b1; rd_E = 5'd8; rs_D = 5'd8; use_rs_D = 1'b1;
        applyStimulus("loaduse_rs", O_STALL, 1'b0);
        clearInputs();
        applyStimulus("loaduse_release", O_RUN, 1'b0);
        memread_E = 1'b1; rd_E = 5'd9; rt_D = 5'd9; use_rt_D = 1'b1;
        applyStimulus("loaduse_rt", O_STALL, 1'b0);
        clearInputs();
        memread_E = 1'b1; rd_E = 5'd9; rs_D = 5'd9; use_rs_D = 1'b0;
        applyStimulus("loaduse_unused", O_RUN, 1'b0);
        clearInputs();
        memread_E = 1'b1; rd_E = 5'd0; rs_D = 5'd0; use_rs_D = 1'b1;
        applyStimulus("load_r0", O_RUN, 1'b0);
        clearInputs();

        md_start_E = 1'b1; md_div_E = 1'b1; md_use_D = 1'b1;
        applyStimulus("div_t0", O_STALL, 1'b0);
        md_start_E = 1'b0; md_div_E = 1'b0;
        for (int i = 1; i <= 10; i++) applyStimulus($sformatf("div_t%0d", i), O_STALL, 1'b1);
        applyStimulus("div_t11", O_RUN, 1'b0);
        clearInputs();

        md_start_E = 1'b1;
        applyStimulus("mult_t0", O_RUN, 1'b0);
        md_start_E = 1'b0; md_use_D = 1'b1;
        applyStimulus("mult_t1", O_STALL, 1'b1);
        applyStimulus("mult_t2", O_STALL, 1'b1);
        exc_req_M = 1'b1;
        applyExc("mult_exc", 1'b1);
        exc_req_M = 1'b0; md_use_D = 1'b0;
        memread_E = 1'b1; rd_E = 5'd4; rs_D = 5'd4; use_rs_D = 1'b1;
        applyStimulus("flush_over_stall", O_FLUSH, 1'b1);
        clearInputs();
        md_use_D = 1'b1;
        applyStimulus("mult_cnt1", O_STALL, 1'b1);
        applyStimulus("mult_cnt0", O_RUN, 1'b0);
        clearInputs();

        exc_req_M = 1'b1; md_start_E = 1'b1;
        applyExc("exc_squash_md", 1'b0);
        md_start_E = 1'b0;
        applyExc("exc_in_flush", 1'b0);
        exc_req_M = 1'b0;
        applyStimulus("flush_after_reexc", O_FLUSH, 1'b0);
        md_use_D = 1'b1;
        applyStimulus("squashed_no_busy", O_RUN, 1'b0);
        clearInputs();

        eret_D = 1'b1; epc_wr_M = 1'b1;
        applyStimulus("eret_wait_M", O_STALL, 1'b0);
        epc_wr_M = 1'b0;
        applyStimulus("eret_go", O_ERET, 1'b0);
        epc_wr_E = 1'b1;
        applyStimulus("eret_wait_E", O_STALL, 1'b0);
        clearInputs();
        applyStimulus("post_eret", O_RUN, 1'b0);

        md_start_E = 1'b1; md_div_E = 1'b1;
        applyStimulus("reload_div", O_RUN, 1'b0);
        md_div_E = 1'b0;
        applyStimulus("reload_mult", O_RUN, 1'b1);
        md_start_E = 1'b0;
        for (int i = 5; i >= 1; i--) applyStimulus($sformatf("reload_cnt%0d", i), O_RUN, 1'b1);
        applyStimulus("reload_done", O_RUN, 1'b0);

        md_start_E = 1'b1; md_div_E = 1'b1;
        applyStimulus("rst_div", O_RUN, 1'b0);
        clearInputs();
        applyStimulus("rst_cnt10", O_RUN, 1'b1);
        applyStimulus("rst_cnt9", O_RUN, 1'b1);
        exc_req_M = 1'b1;
        applyExc("rst_exc_cnt8", 1'b1);
        exc_req_M = 1'b0;
        reset = 1'b0;
        applyStimulus("rst_in_flush", O_RESET, 1'b0);
        reset = 1'b1; md_use_D = 1'b1;
        applyStimulus("rst_cleared", O_RUN, 1'b0);
        clearInputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage MIPS pipeline.
- Produces the enable and clear controls for the PC, the IF/ID register, and the ID/EX register, plus int_clr and ERET_PC_sel.
- Inputs are decode-stage operand usage, E/M-stage hazard sources, a multiply/divide busy tracker, and exception/ERET requests.
- Sits beside the hazard unit in the top-level core and replaces ad-hoc stall glue.

Parameters:
- MULT_CYC, 5, cycles HI/LO stays busy after a mult/multu issues in E.
- DIV_CYC, 10, cycles HI/LO stays busy after a div/divu issues in E.
- CNT_W, 4, busy counter width; must satisfy 2^CNT_W > max(MULT_CYC, DIV_CYC).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset; reset==0 at a posedge resets state.
- rs_D, rt_D  in  5 each  D-stage source register numbers.
- use_rs_D, use_rt_D  in  1 each  D-stage instruction reads rs/rt in D or E.
- md_use_D  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
- memread_E  in  1  E-stage instruction is a load.
- rd_E  in  5  E-stage destination register.
- md_start_E  in  1  E-stage instruction is mult/div (one-cycle qualifier).
- md_div_E  in  1  the started op is a divide (selects DIV_CYC).
- eret_D  in  1  D-stage instruction is ERET.
- epc_wr_E, epc_wr_M  in  1 each  mtc0 to EPC in E or M.
- exc_req_M  in  1  exception/interrupt accepted at M this cycle.
- pc_en  out  1  PC update enable.
- IF_ID_en  out  1  IF/ID register load enable.
- IF_ID_clr  out  1  IF/ID register synchronous clear.
- ID_EX_clr  out  1  ID/EX register clear (bubble insert).
- int_clr  out  1  flush-all pulse to the pipeline registers.
- ERET_PC_sel  out  1  PC mux selects EPC.
- md_busy  out  1  busy counter is non-zero.

Behaviour:
- State: fsm in {RUN, FLUSH}, busy counter cnt[CNT_W-1:0]. Outputs are combinational from state and inputs.
- While reset==0:
  - pc_en=0, IF_ID_en=0, IF_ID_clr=1, ID_EX_clr=1, int_clr=0, ERET_PC_sel=0, md_busy=0.
  - At the posedge: fsm<=RUN, cnt<=0.
- Hazard terms:
  - lu = memread_E & (rd_E!=0) & ((use_rs_D & rs_D==rd_E) | (use_rt_D & rt_D==rd_E)).
  - ms = md_use_D & (cnt!=0 | md_start_E).
  - es = eret_D & (epc_wr_E | epc_wr_M).
  - stall = lu | ms | es.
- Priority: exc_req_M > FLUSH > stall > ERET > normal.
- exc_req_M=1 (any state):
  - int_clr=1, pc_en=1 (handler vector loads), IF_ID_en=0, ID_EX_clr=1, ERET_PC_sel=0.
  - Next fsm=FLUSH.
  - A md_start_E in the same cycle is ignored (the younger op is squashed). An existing cnt keeps counting.
- FLUSH (one cycle):
  - IF_ID_clr=1, ID_EX_clr=1, pc_en=1, IF_ID_en=0, int_clr=0.
  - Next fsm=RUN unless exc_req_M re-asserts, in which case the exception row applies.
- RUN with stall:
  - pc_en=0, IF_ID_en=0, ID_EX_clr=1, IF_ID_clr=0.
  - Stall persists every cycle its term holds; no extra cycles are added.
- RUN, no stall, eret_D:
  - ERET_PC_sel=1, pc_en=1, IF_ID_en=1, IF_ID_clr=1. The delay-slot fetch is discarded.
- RUN, otherwise: pc_en=1, IF_ID_en=1, both clears 0.
- Counter update:
  - md_start_E & !exc_req_M: cnt <= md_div_E ? DIV_CYC : MULT_CYC. This reloads even if cnt!=0.
  - Else if cnt!=0: cnt <= cnt-1.
  - Saturates at 0; never wraps.
- md_busy = (cnt!=0).
- Reset mid-stall or mid-FLUSH: the reset row wins; no state survives.

Decomposition:
- Shared package/header holds:
  - FSM encodings ST_RUN=1'b0, ST_FLUSH=1'b1.
  - MULT_CYC/DIV_CYC defaults.
  - The `F`/`EXC` widths already in head.h.
- One sub-module: md_busy_cnt (load/decrement/zero-detect counter), instantiated once.

Test Plan:
- Load-use: memread_E=1, rd_E=8, rs_D=8, use_rs_D=1 for 1 cycle -> pc_en=0, IF_ID_en=0, ID_EX_clr=1 that cycle only; next cycle pc_en=1.
- Load to $0: rd_E=0, rs_D=0, use_rs_D=1, memread_E=1 -> no stall.
- Divide: md_start_E=1, md_div_E=1 at t0, then md_use_D=1 held -> cnt 10..1, stall cycles t0..t10; pc_en returns to 1 at t11 and md_busy falls at t11.
- Exception during a mult stall: cnt=3, exc_req_M=1 -> int_clr=1, pc_en=1 that cycle. Next cycle FLUSH gives IF_ID_clr=1. cnt continues 2,1,0.
- ERET after mtc0 EPC: eret_D=1, epc_wr_M=1 -> stall, ERET_PC_sel=0. Next cycle epc_wr_M=0 -> ERET_PC_sel=1, IF_ID_clr=1.
- Reset: reset=0 while fsm=FLUSH and cnt=7 -> next cycle fsm=RUN, cnt=0, md_busy=0; outputs at reset values while reset held.
